pwm_ramp_scheduler: RTL and testbench

Sequencer that shares one PWM compare write bus between eight PWM channels and moves each channel's compare value toward a host-set target in bounded steps. Host commands arrive as single-cycle decoded writes from the SPI front end. On each ramp tick the block scans every channel round-robin and issues one-hot write strobes plus a compare value to the PWM generator bank. It sits between the SPI command decode and the `pwm_generator` instances, and replaces direct compare writes.

---
 rtl/pwm_ramp_pkg.sv | 16 +
 rtl/pwm_ramp_scheduler_if.sv | 26 ++
 rtl/pwm_ramp_step.sv | 27 ++
 rtl/pwm_ramp_scheduler.sv | 157 +++++++++++++++
 tb/tb_pwm_ramp_scheduler.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_ramp_pkg.sv
// Shared types and constants for the PWM ramp scheduler.
// Optional feature macro: PWM_RAMP_SNAP_EN (snap command on ADDR_SNAP).
package pwm_ramp_pkg;

    localparam int CMP_SIZE_DEFAULT = 10;

    localparam logic [3:0] ADDR_STEP    = 4'd8;
    localparam logic [3:0] ADDR_CLR_OVR = 4'd9;
    localparam logic [3:0] ADDR_SNAP    = 4'd10;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/pwm_ramp_scheduler_if.sv
// Host command / PWM compare bus between the SPI decode,
// the ramp scheduler and the PWM generator bank.
interface pwm_ramp_scheduler_if #(
    parameter int COMPARE_SIZE = 10,
    parameter int CHANNELS     = 8
);
    logic                    cmd_valid;
    logic [3:0]              cmd_addr;
    logic [COMPARE_SIZE-1:0] cmd_data;
    logic                    tick;
    logic [CHANNELS-1:0]     pwm_wr;
    logic [COMPARE_SIZE-1:0] pwm_compare;
    logic                    busy;
    logic                    settled;
    logic                    overrun;

    modport master (
        output cmd_valid, cmd_addr, cmd_data, tick,
        input  pwm_wr, pwm_compare, busy, settled, overrun
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_data, tick,
        output pwm_wr, pwm_compare, busy, settled, overrun
    );
endinterface

// File: rtl/pwm_ramp_step.sv
// Next compare value: move current toward target by at most step,
// never overshooting and never wrapping.
module pwm_ramp_step #(
    parameter int W = 10
) (
    input  logic [W-1:0] current,
    input  logic [W-1:0] target,
    input  logic [W-1:0] step,
    output logic [W-1:0] nxt,
    output logic         differs
);
    logic [W:0]   w_diff;
    logic [W:0]   w_neg;
    logic         w_up;
    logic [W-1:0] w_mag;
    logic [W-1:0] w_delta;

    always_comb begin
        w_diff  = {1'b0, target} - {1'b0, current};
        w_neg   = '0 - w_diff;
        w_up    = ~w_diff[W];
        w_mag   = w_up ? w_diff[W-1:0] : w_neg[W-1:0];
        w_delta = (step < w_mag) ? step : w_mag;
        nxt     = w_up ? (current + w_delta) : (current - w_delta);
        differs = |w_diff;
    end
endmodule

// File: rtl/pwm_ramp_scheduler.sv
// Round-robin ramp scheduler driving one shared PWM compare write bus.
// Define PWM_RAMP_SNAP_EN to enable the snap command (addr ADDR_SNAP).
module pwm_ramp_scheduler
    import pwm_ramp_pkg::*;
#(
    parameter int COMPARE_SIZE = CMP_SIZE_DEFAULT,
    parameter int CHANNELS     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_ramp_scheduler_if.slave  bus
);
    localparam int IW = 3;
    localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);

    typedef logic [COMPARE_SIZE-1:0] val_t;

    state_t              r_state, w_state_nxt;
    logic [IW-1:0]       r_idx, w_idx_nxt;
    logic                r_pending, w_pending_nxt;
    logic                r_overrun, w_overrun_nxt;

    val_t                r_step;
    val_t                r_target  [CHANNELS];
    val_t                r_current [CHANNELS];
    logic [CHANNELS-1:0] r_pwm_wr;
    val_t                r_pwm_compare;
    logic                r_settled;

    val_t                w_cur, w_tgt, w_nxt;
    logic                w_differs, w_svc;
    logic                w_tgt_wr, w_step_wr, w_clr_ovr;
    logic [CHANNELS-1:0] w_snap;
    logic [CHANNELS-1:0] w_onehot;
    logic                w_all_eq;

    always_comb begin
        w_tgt_wr  = 1'b0;
        w_step_wr = 1'b0;
        w_clr_ovr = 1'b0;
        w_snap    = '0;
        if (bus.cmd_valid) begin
            unique case (1'b1)
                (bus.cmd_addr < 4'(CHANNELS)):    w_tgt_wr  = 1'b1;
                (bus.cmd_addr == ADDR_STEP):      w_step_wr = 1'b1;
                (bus.cmd_addr == ADDR_CLR_OVR):   w_clr_ovr = 1'b1;
`ifdef PWM_RAMP_SNAP_EN
                (bus.cmd_addr == ADDR_SNAP):      w_snap = bus.cmd_data[CHANNELS-1:0];
`endif
                default: ;
            endcase
        end
    end

    // Service always sees the registered target, so a same-cycle
    // target write only takes effect on the next scan.
    assign w_cur = r_current[r_idx];
    assign w_tgt = r_target[r_idx];

    pwm_ramp_step #(.W(COMPARE_SIZE)) u_step (
        .current (w_cur),
        .target  (w_tgt),
        .step    (r_step),
        .nxt     (w_nxt),
        .differs (w_differs)
    );

    assign w_svc = (r_state == SCAN) && w_differs;

    always_comb begin
        w_onehot = '0;
        w_onehot[r_idx] = 1'b1;
    end

    always_comb begin
        w_all_eq = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_current[i] != r_target[i]) w_all_eq = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_pending_nxt = r_pending;
        w_overrun_nxt = r_overrun;
        if (w_clr_ovr) w_overrun_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.tick) begin
                    w_state_nxt = SCAN;
                    w_idx_nxt   = '0;
                end
            end
            SCAN: begin
                if (bus.tick) begin
                    if (r_pending) w_overrun_nxt = 1'b1;
                    else           w_pending_nxt = 1'b1;
                end
                if (r_idx == LAST) begin
                    w_idx_nxt     = '0;
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = (r_pending || bus.tick) ? SCAN : IDLE;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_pending <= w_pending_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step        <= val_t'(1);
            r_pwm_wr      <= '0;
            r_pwm_compare <= '0;
            r_settled     <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                r_target[i]  <= '0;
                r_current[i] <= '0;
            end
        end else begin
            if (w_step_wr) begin
                r_step <= (bus.cmd_data == '0) ? val_t'(1) : bus.cmd_data;
            end
            r_pwm_wr <= w_svc ? w_onehot : '0;
            if (w_svc) r_pwm_compare <= w_nxt;
            r_settled <= w_all_eq;
            // Snap is applied after service so it wins on collision.
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_svc && (r_idx == IW'(i))) r_current[i] <= w_nxt;
                if (w_snap[i]) r_current[i] <= r_target[i];
                if (w_tgt_wr && (bus.cmd_addr == 4'(i))) r_target[i] <= bus.cmd_data;
            end
        end
    end

    assign bus.pwm_wr      = r_pwm_wr;
    assign bus.pwm_compare = r_pwm_compare;
    assign bus.busy        = (r_state == SCAN);
    assign bus.settled     = r_settled;
    assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Directed bench for pwm_ramp_scheduler: vector table of commands and
// ticks with expected strobes, plus hand-written multi-cycle sequences.
module tb_pwm_ramp_scheduler;
    localparam int CW = 10;
    localparam int CH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_ramp_scheduler_if #(.COMPARE_SIZE(CW), .CHANNELS(CH)) bus ();

    pwm_ramp_scheduler #(.COMPARE_SIZE(CW), .CHANNELS(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit            is_tick;
        logic [3:0]    addr;
        logic [CW-1:0] data;
        logic [CH-1:0] exp_wr;
        logic [CW-1:0] exp_cmp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t vc(input int a, input int d);
        vec_t v;
        v.is_tick = 1'b0;
        v.addr    = 4'(a);
        v.data    = CW'(d);
        v.exp_wr  = '0;
        v.exp_cmp = '0;
        return v;
    endfunction

    function automatic vec_t vt(input int ch, input int val);
        vec_t v;
        v.is_tick = 1'b1;
        v.addr    = '0;
        v.data    = '0;
        v.exp_wr  = '0;
        if (ch >= 0) v.exp_wr[ch] = 1'b1;
        v.exp_cmp = CW'(val);
        return v;
    endfunction

    task automatic cmd(input int a, input int d);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 4'(a);
        bus.cmd_data  = CW'(d);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // One tick, then watch the following scan window.
    task automatic scan(input logic [CW-1:0] exp_cmp,
                        output logic [CH-1:0] wr_or, output int nstb,
                        output int ncmp_bad, output int bad_pos,
                        output int nbusy);
        logic [CH-1:0] oh;
        wr_or = '0; nstb = 0; ncmp_bad = 0; bad_pos = 0; nbusy = 0;
        @(negedge clk);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        if (bus.busy) nbusy++;
        for (int j = 0; j < CH + 1; j++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.pwm_wr != '0) begin
                nstb++;
                wr_or |= bus.pwm_wr;
                if (bus.pwm_compare != exp_cmp) ncmp_bad++;
                oh = '0;
                if (j < CH) oh[j] = 1'b1;
                if (bus.pwm_wr != oh) bad_pos++;
            end
        end
    endtask

    task automatic tick_window(input int t0, input int t1,
                               output int nb, output int ns,
                               output logic [CW-1:0] lc,
                               output logic [CH-1:0] wr_or);
        nb = 0; ns = 0; lc = '0; wr_or = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c > 0) begin
                if (bus.busy) nb++;
                if (bus.pwm_wr != '0) begin
                    ns++;
                    lc = bus.pwm_compare;
                    wr_or |= bus.pwm_wr;
                end
            end
            bus.tick = (c == 0) || (c == t0) || (c == t1);
        end
        bus.tick = 1'b0;
    endtask

    initial begin
        logic [CH-1:0] wr_or;
        logic [CW-1:0] lc;
        int nstb, ncb, bpos, nbusy, nb, ns;

        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.tick      = 1'b0;

        vecs.push_back(vc(3, 10));
        for (int i = 1; i <= 10; i++) vecs.push_back(vt(3, i));
        vecs.push_back(vt(-1, 0));
        vecs.push_back(vc(8, 100));
        vecs.push_back(vc(0, 250));
        vecs.push_back(vt(0, 100));
        vecs.push_back(vt(0, 200));
        vecs.push_back(vt(0, 250));
        vecs.push_back(vc(0, 0));
        vecs.push_back(vt(0, 150));
        vecs.push_back(vt(0, 50));
        vecs.push_back(vt(0, 0));
        vecs.push_back(vc(8, 0));
        vecs.push_back(vc(1, 3));
        vecs.push_back(vt(1, 1));
        vecs.push_back(vt(1, 2));
        vecs.push_back(vt(1, 3));
        vecs.push_back(vt(-1, 0));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pwm_wr",  32'(bus.pwm_wr), 0);
        chk("rst_compare", 32'(bus.pwm_compare), 0);
        chk("rst_busy",    32'(bus.busy), 0);
        chk("rst_settled", 32'(bus.settled), 1);
        chk("rst_overrun", 32'(bus.overrun), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (!vecs[i].is_tick) begin
                cmd(int'(vecs[i].addr), int'(vecs[i].data));
            end else begin
                scan(vecs[i].exp_cmp, wr_or, nstb, ncb, bpos, nbusy);
                chk($sformatf("v%0d_wr", i), 32'(wr_or), 32'(vecs[i].exp_wr));
                chk($sformatf("v%0d_nstb", i), nstb,
                    (vecs[i].exp_wr != '0) ? 1 : 0);
                chk($sformatf("v%0d_cmp", i), ncb, 0);
                chk($sformatf("v%0d_pos", i), bpos, 0);
                chk($sformatf("v%0d_busy", i), nbusy, CH);
            end
        end
        repeat (2) @(negedge clk);
        chk("tbl_settled", 32'(bus.settled), 1);

        // Two extra ticks in one scan: one rescan plus overrun.
        cmd(5, 20);
        tick_window(3, 5, nb, ns, lc, wr_or);
        chk("ovr_busy",    nb, 16);
        chk("ovr_nstb",    ns, 2);
        chk("ovr_cmp",     32'(lc), 2);
        chk("ovr_wr",      32'(wr_or), 32'h20);
        chk("ovr_flag",    32'(bus.overrun), 1);
        cmd(9, 0);
        chk("ovr_clear",   32'(bus.overrun), 0);

        // Tick in the final scan cycle still triggers a rescan.
        tick_window(8, 8, nb, ns, lc, wr_or);
        chk("last_busy",   nb, 16);
        chk("last_nstb",   ns, 2);
        chk("last_cmp",    32'(lc), 4);
        chk("last_ovr",    32'(bus.overrun), 0);

        // All channels reach 5 in one scan.
        for (int c = 0; c < CH; c++) cmd(c, 5);
        cmd(8, 5);
        scan(CW'(5), wr_or, nstb, ncb, bpos, nbusy);
        chk("all_wr",   32'(wr_or), 32'hFF);
        chk("all_nstb", nstb, 8);
        chk("all_cmp",  ncb, 0);
        chk("all_pos",  bpos, 0);
        chk("all_busy", nbusy, 8);
        repeat (2) @(negedge clk);
        chk("all_settled", 32'(bus.settled), 1);

        // Reset right after the channel 2 strobe.
        for (int c = 0; c < CH; c++) cmd(c, 9);
        @(negedge clk);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_ch2_wr", 32'(bus.pwm_wr), 32'h04);
        rst = 1'b1;
        #1;
        chk("mid_rst_wr",   32'(bus.pwm_wr), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_cmp",  32'(bus.pwm_compare), 0);
        @(negedge clk);
        rst = 1'b0;
        ns = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.pwm_wr != '0) ns++;
        end
        chk("mid_no_strobe", ns, 0);
        chk("mid_settled",   32'(bus.settled), 1);
        cmd(0, 1);
        scan(CW'(1), wr_or, nstb, ncb, bpos, nbusy);
        chk("post_rst_wr",  32'(wr_or), 32'h01);
        chk("post_rst_cmp", ncb, 0);
        chk("post_rst_n",   nstb, 1);

`ifdef PWM_RAMP_SNAP_EN
        cmd(4, 7);
        cmd(10, 32'h10);
        repeat (2) @(negedge clk);
        chk("snap_settled", 32'(bus.settled), 1);
        scan(CW'(0), wr_or, nstb, ncb, bpos, nbusy);
        chk("snap_wr",   32'(wr_or), 0);
        chk("snap_nstb", nstb, 0);
`else
        cmd(4, 7);
        cmd(10, 32'h10);
        scan(CW'(1), wr_or, nstb, ncb, bpos, nbusy);
        chk("nosnap_wr",  32'(wr_or), 32'h10);
        chk("nosnap_cmp", ncb, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
